// File: rtl/logic_op_decoder.sv
// logic_op_decoder
// Issue-side controller for the 32-bit logic unit. It accepts one R-type
// instruction word at a time over a valid/ready handshake. It decodes funct into
// the logic unit's 3-bit function code. It then sequences a synchronous regfile
// read, one logic-unit evaluation and a single write-back.
//
// Build option:
//   SHIFT_VAR_EN  when defined, the variable shifts SLLV/SRLV/SRAV are legal.
//                 They take their shift amount from RsData[4:0].
//                 When undefined, those funct codes take the illegal path.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | InstrReady high; the instruction is decoded and latched on accept
// READ  | rs/rt addresses presented to the regfile
// EXEC  | operands and function code driven to logic unit; result captured
// WB    | one-cycle write-back pulse (suppressed when rd is r0)
// ERR   | one-cycle IllegalInstr pulse, no regfile traffic

module logic_op_decoder #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              InstrValid,
   output logic              InstrReady,
   input  logic [31:0]       Instr,
   output logic [REG_AW-1:0] RsAddr,
   output logic [REG_AW-1:0] RtAddr,
   input  logic [DATA_W-1:0] RsData,
   input  logic [DATA_W-1:0] RtData,
   output logic [DATA_W-1:0] LuX,
   output logic [DATA_W-1:0] LuY,
   output logic [2:0]        LuFunc,
   input  logic [DATA_W-1:0] LuOut,
   output logic              WbEn,
   output logic [REG_AW-1:0] WbAddr,
   output logic [DATA_W-1:0] WbData,
   output logic              IllegalInstr
);

   localparam logic [2:0] FN_AND = 3'b000;
   localparam logic [2:0] FN_XOR = 3'b001;
   localparam logic [2:0] FN_SLL = 3'b010;
   localparam logic [2:0] FN_SRL = 3'b110;
   localparam logic [2:0] FN_SRA = 3'b100;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      EXEC = 3'd2,
      WB   = 3'd3,
      ERR  = 3'd4
   } stateT;

   stateT      state;

   // Decode results for the word currently on Instr.
   logic       decLegal;
   logic [2:0] decFunc;
   logic       decShift;
   logic       decVar;

   // Fields latched at accept.
   logic [2:0] funcQ;
   logic       shiftQ;
   logic       varQ;
   logic [4:0] shamtQ;
   logic [4:0] rdQ;

   // Decode funct to the logic-unit code; only op 0 carries logic-unit work.
   always_comb begin
      decLegal = 1'b0;
      decFunc  = FN_AND;
      decShift = 1'b0;
      decVar   = 1'b0;
      if (Instr[31:26] == 6'h00) begin
         case (Instr[5:0])
            6'h24: begin decLegal = 1'b1; decFunc = FN_AND; end
            6'h26: begin decLegal = 1'b1; decFunc = FN_XOR; end
            6'h00: begin decLegal = 1'b1; decFunc = FN_SLL; decShift = 1'b1; end
            6'h02: begin decLegal = 1'b1; decFunc = FN_SRL; decShift = 1'b1; end
            6'h03: begin decLegal = 1'b1; decFunc = FN_SRA; decShift = 1'b1; end
`ifdef SHIFT_VAR_EN
            6'h04: begin decLegal = 1'b1; decFunc = FN_SLL; decShift = 1'b1; decVar = 1'b1; end
            6'h06: begin decLegal = 1'b1; decFunc = FN_SRL; decShift = 1'b1; decVar = 1'b1; end
            6'h07: begin decLegal = 1'b1; decFunc = FN_SRA; decShift = 1'b1; decVar = 1'b1; end
`endif
            default: decLegal = 1'b0;
         endcase
      end
   end

   // Operand steering. Read data only becomes valid during EXEC (synchronous
   // regfile read), so X/Y cannot be registered without adding a cycle of
   // latency; they are state-gated muxes instead. Shift amounts are always
   // masked to 5 bits, so the logic unit never sees a shift above 31.
   always_comb begin
      LuX = '0;
      LuY = '0;
      if (state == EXEC) begin
         LuX = shiftQ ? RtData : RsData;
         if (!shiftQ)
            LuY = RtData;
         else if (varQ)
            LuY = {{(DATA_W-5){1'b0}}, RsData[4:0]};
         else
            LuY = {{(DATA_W-5){1'b0}}, shamtQ};
      end
   end

   // Sequencer: state plus all registered outputs; reset drops any in-flight op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         InstrReady   <= 1'b1;
         RsAddr       <= '0;
         RtAddr       <= '0;
         LuFunc       <= FN_AND;
         WbEn         <= 1'b0;
         WbAddr       <= '0;
         WbData       <= '0;
         IllegalInstr <= 1'b0;
         funcQ        <= FN_AND;
         shiftQ       <= 1'b0;
         varQ         <= 1'b0;
         shamtQ       <= '0;
         rdQ          <= '0;
      end else begin
         WbEn         <= 1'b0;
         IllegalInstr <= 1'b0;
         case (state)
            IDLE: begin
               if (InstrValid) begin
                  InstrReady <= 1'b0;
                  if (decLegal) begin
                     state  <= READ;
                     RsAddr <= REG_AW'(Instr[25:21]);
                     RtAddr <= REG_AW'(Instr[20:16]);
                     funcQ  <= decFunc;
                     shiftQ <= decShift;
                     varQ   <= decVar;
                     shamtQ <= Instr[10:6];
                     rdQ    <= Instr[15:11];
                  end else begin
                     state        <= ERR;
                     IllegalInstr <= 1'b1;
                  end
               end
            end
            READ: begin
               state  <= EXEC;
               LuFunc <= funcQ;
            end
            EXEC: begin
               state  <= WB;
               RsAddr <= '0;
               RtAddr <= '0;
               LuFunc <= FN_AND;
               WbEn   <= (rdQ != 5'd0);
               WbAddr <= REG_AW'(rdQ);
               WbData <= LuOut;
            end
            WB: begin
               state      <= IDLE;
               WbAddr     <= '0;
               WbData     <= '0;
               InstrReady <= 1'b1;
            end
            ERR: begin
               state      <= IDLE;
               InstrReady <= 1'b1;
            end
            default: begin
               state      <= IDLE;
               InstrReady <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_logic_op_decoder.sv
// tb_logic_op_decoder
// Surrounds the decoder with a synchronous-read regfile and a behavioural logic
// unit. It drives directed and random R-type words. For every accepted word it
// queues the cycle-exact expected responses, and a negedge monitor checks them.
// Honours SHIFT_VAR_EN the same way the design does.

module tb_logic_op_decoder;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   localparam int K_READ = 0;
   localparam int K_EXEC = 1;
   localparam int K_WB   = 2;
   localparam int K_ILL  = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              InstrValid = 1'b0;
   logic              InstrReady;
   logic [31:0]       Instr = '0;
   logic [REG_AW-1:0] RsAddr, RtAddr;
   logic [DATA_W-1:0] RsData, RtData;
   logic [DATA_W-1:0] LuX, LuY;
   logic [2:0]        LuFunc;
   logic [DATA_W-1:0] LuOut;
   logic              WbEn;
   logic [REG_AW-1:0] WbAddr;
   logic [DATA_W-1:0] WbData;
   logic              IllegalInstr;

   logic [31:0] rf   [32];
   logic [31:0] mrf  [32];
   logic [31:0] snap [32];
   logic        tbWe = 1'b0;
   logic [4:0]  tbWa = '0;
   logic [31:0] tbWd = '0;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      int          due;
      int          kind;
      logic [4:0]  r0;
      logic [4:0]  r1;
      logic [2:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      bit          en;
   } expT;

   expT sb[$];

   logic_op_decoder #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr),
      .RsAddr(RsAddr), .RtAddr(RtAddr), .RsData(RsData), .RtData(RtData),
      .LuX(LuX), .LuY(LuY), .LuFunc(LuFunc), .LuOut(LuOut),
      .WbEn(WbEn), .WbAddr(WbAddr), .WbData(WbData),
      .IllegalInstr(IllegalInstr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Regfile: synchronous read, r0 reads zero, written by DUT write-back or bench setup.
   always @(posedge clk) begin
      RsData <= (RsAddr == 5'd0) ? 32'd0 : rf[RsAddr];
      RtData <= (RtAddr == 5'd0) ? 32'd0 : rf[RtAddr];
      if (WbEn) rf[WbAddr] <= WbData;
      if (tbWe) rf[tbWa] <= tbWd;
   end

   // Logic unit, written from the function-code table.
   always_comb begin
      case (LuFunc)
         3'b000:  LuOut = LuX & LuY;
         3'b001:  LuOut = LuX ^ LuY;
         3'b010:  LuOut = LuX << LuY[4:0];
         3'b110:  LuOut = LuX >> LuY[4:0];
         3'b100:  LuOut = $unsigned($signed(LuX) >>> LuY[4:0]);
         default: LuOut = 32'hDEAD_BEEF;
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [5:0] fn);
      return {op, rs, rt, rd, sh, fn};
   endfunction

   // Reference: what the instruction means architecturally, from the register model.
   function automatic void refModel(input logic [31:0] ins, output bit legal,
                                    output logic [2:0] fn, output logic [31:0] x,
                                    output logic [31:0] y, output logic [31:0] res);
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      a  = mrf[ins[25:21]];
      b  = mrf[ins[20:16]];
      sh = ins[10:6];
      legal = 1'b1; fn = 3'b000; x = '0; y = '0; res = '0;
      if (ins[31:26] != 6'h00) legal = 1'b0;
      else begin
         case (ins[5:0])
            6'h24: begin fn = 3'b000; x = a; y = b; res = a & b; end
            6'h26: begin fn = 3'b001; x = a; y = b; res = a ^ b; end
            6'h00: begin fn = 3'b010; x = b; y = 32'(sh); res = b << sh; end
            6'h02: begin fn = 3'b110; x = b; y = 32'(sh); res = b >> sh; end
            6'h03: begin fn = 3'b100; x = b; y = 32'(sh); res = $unsigned($signed(b) >>> sh); end
`ifdef SHIFT_VAR_EN
            6'h04: begin fn = 3'b010; x = b; y = 32'(a[4:0]); res = b << a[4:0]; end
            6'h06: begin fn = 3'b110; x = b; y = 32'(a[4:0]); res = b >> a[4:0]; end
            6'h07: begin fn = 3'b100; x = b; y = 32'(a[4:0]); res = $unsigned($signed(b) >>> a[4:0]); end
`endif
            default: legal = 1'b0;
         endcase
      end
   endfunction

   task automatic pushExpect(input logic [31:0] ins, input int t);
      bit          legal;
      logic [2:0]  fn;
      logic [31:0] x, y, res;
      expT         e;
      refModel(ins, legal, fn, x, y, res);
      e.r0 = '0; e.r1 = '0; e.fn = '0; e.a = '0; e.b = '0; e.en = 1'b0;
      if (legal) begin
         e.due = t + 1; e.kind = K_READ; e.r0 = ins[25:21]; e.r1 = ins[20:16];
         sb.push_back(e);
         e.due = t + 2; e.kind = K_EXEC; e.fn = fn; e.a = x; e.b = y;
         sb.push_back(e);
         e.due = t + 3; e.kind = K_WB; e.r0 = ins[15:11]; e.a = res; e.en = (ins[15:11] != 5'd0);
         sb.push_back(e);
         if (ins[15:11] != 5'd0) mrf[ins[15:11]] = res;
      end else begin
         e.due = t + 1; e.kind = K_ILL;
         sb.push_back(e);
      end
   endtask

   // Monitor: expected activity on due cycles, quiet idle outputs otherwise.
   always @(negedge clk) begin : monitor
      expT e;
      while (sb.size() > 0 && sb[0].due < cyc) begin
         tests++; fails++;
         $display("FAIL sb_stale: entry due %0d not seen, now cycle %0d", sb[0].due, cyc);
         void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         case (e.kind)
            K_READ: begin
               chk("read_addr", {InstrReady, LuFunc, RsAddr, RtAddr}, {1'b0, 3'b000, e.r0, e.r1});
               chk("read_nowb", WbEn, 1'b0);
            end
            K_EXEC: begin
               chk("exec_func", {InstrReady, WbEn, LuFunc}, {1'b0, 1'b0, e.fn});
               chk("exec_x", LuX, e.a);
               chk("exec_y", LuY, e.b);
            end
            K_WB: begin
               chk("wb_ctl", {InstrReady, WbEn, WbAddr, LuFunc}, {1'b0, e.en, e.r0, 3'b000});
               chk("wb_data", WbData, e.a);
               chk("wb_quiet", {LuX | LuY, 3'b000, RsAddr, RtAddr}, '0);
            end
            default: begin
               chk("ill_pulse", {InstrReady, IllegalInstr, WbEn, RsAddr, RtAddr}, {1'b0, 1'b1, 1'b0, 10'd0});
            end
         endcase
      end else begin
         chk("idle_ctl", {InstrReady, WbEn, IllegalInstr, LuFunc, RsAddr, RtAddr},
                         {1'b1, 1'b0, 1'b0, 3'b000, 10'd0});
         chk("idle_data", {LuX | LuY | WbData, 27'd0, WbAddr}, '0);
      end
   end

   task automatic setReg(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      tbWe = 1'b1; tbWa = a; tbWd = d;
      @(negedge clk);
      tbWe = 1'b0;
      mrf[a] = d;
   endtask

   // Present ins with valid held high; while the DUT is busy, garbage is shown instead.
   task automatic issueOne(input logic [31:0] ins, output int t);
      int waitN = 0;
      @(negedge clk);
      while (!InstrReady && waitN < 20) begin
         InstrValid = 1'b1;
         Instr = $urandom;
         waitN++;
         @(negedge clk);
      end
      if (!InstrReady) begin
         tests++; fails++;
         $display("FAIL ready_timeout: InstrReady still %b after %0d cycles", InstrReady, waitN);
         t = -1;
      end else begin
         InstrValid = 1'b1;
         Instr = ins;
         t = cyc;
         pushExpect(ins, t);
      end
   endtask

   task automatic dropValid();
      @(negedge clk);
      InstrValid = 1'b0;
      Instr = $urandom;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0) begin
         tests++; fails++;
         $display("FAIL drain_timeout: %0d expected events still pending", sb.size());
         sb.delete();
      end
   endtask

   function automatic logic [31:0] randInstr();
      logic [5:0] fn;
      logic [5:0] op;
      case ($urandom_range(0, 8))
         0: fn = 6'h24;
         1: fn = 6'h26;
         2: fn = 6'h00;
         3: fn = 6'h02;
         4: fn = 6'h03;
         5: fn = 6'h04;
         6: fn = 6'h06;
         7: fn = 6'h07;
         default: fn = 6'($urandom);
      endcase
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'h00;
      return rtype(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), fn);
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int acc[3];
      mrf[0] = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_state", {InstrReady, WbEn, IllegalInstr, LuFunc, RsAddr, RtAddr, WbAddr},
                         {1'b1, 1'b0, 1'b0, 3'b000, 15'd0});
      for (int i = 1; i < 32; i++) setReg(5'(i), $urandom);
      @(negedge clk);
      #2 rst_n = 1'b1;

      // AND r3 = r1 & r2
      setReg(5'd1, 32'hF0F0_F0F0);
      setReg(5'd2, 32'hFF00_FF00);
      issueOne(rtype(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h24), t);
      dropValid();
      drain();

      // SRA / SRL of 0x80000000 by 4 into r4
      setReg(5'd8, 32'h8000_0000);
      issueOne(rtype(6'h00, 5'd0, 5'd8, 5'd4, 5'd4, 6'h03), t);
      dropValid();
      drain();
      issueOne(rtype(6'h00, 5'd0, 5'd8, 5'd4, 5'd4, 6'h02), t);
      dropValid();
      drain();

      // Illegal op, then XOR to r0 (no write-back)
      issueOne(rtype(6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h24), t);
      dropValid();
      drain();
      issueOne(rtype(6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h26), t);
      dropValid();
      drain();

      // SLLV r5 = r7 << r6[4:0] (legal only with variable shifts enabled)
      setReg(5'd6, 32'h0000_0024);
      setReg(5'd7, 32'h0000_0001);
      issueOne(rtype(6'h00, 5'd6, 5'd7, 5'd5, 5'd0, 6'h04), t);
      dropValid();
      drain();

      // Three queued instructions with valid held high
      issueOne(rtype(6'h00, 5'd1, 5'd2, 5'd10, 5'd0, 6'h26), acc[0]);
      issueOne(rtype(6'h00, 5'd0, 5'd1, 5'd11, 5'd7, 6'h00), acc[1]);
      issueOne(rtype(6'h00, 5'd10, 5'd2, 5'd12, 5'd0, 6'h24), acc[2]);
      dropValid();
      drain();
      chk("b2b_gap01", 32'(acc[1] - acc[0]), 32'd4);
      chk("b2b_gap12", 32'(acc[2] - acc[1]), 32'd4);

      // Reset asserted in the middle of EXEC
      setReg(5'd1, 32'hF0F0_F0F0);
      setReg(5'd2, 32'hFF00_FF00);
      snap = mrf;
      issueOne(rtype(6'h00, 5'd1, 5'd2, 5'd9, 5'd0, 6'h24), t);
      dropValid();
      @(negedge clk);
      #2 rst_n = 1'b0;
      sb.delete();
      #1;
      chk("rst_exec_ctl", {InstrReady, WbEn, IllegalInstr, LuFunc, RsAddr, RtAddr, WbAddr},
                          {1'b1, 1'b0, 1'b0, 3'b000, 15'd0});
      chk("rst_exec_data", LuX | LuY | WbData, 32'd0);
      mrf = snap;
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (6) @(negedge clk);

      // Random traffic with random idle gaps
      for (int n = 0; n < 200; n++) begin
         issueOne(randInstr(), t);
         if ($urandom_range(0, 2) == 0) begin
            dropValid();
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      dropValid();
      drain();
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
